// File: rtl/seq_mon_pkg.sv
// Shared types for the a ##1 b ##1 c ##1 !c expect monitor: FSM states,
// sticky failure codes and the width of the failure code field.
package seq_mon_pkg;

   localparam int FAIL_STAGE_W = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EXP_A  = 3'd1,
      EXP_B  = 3'd2,
      EXP_C  = 3'd3,
      EXP_NC = 3'd4
   } seq_state_e;

   typedef enum logic [FAIL_STAGE_W-1:0] {
      FS_NONE      = 3'd0,
      FS_A_MISSING = 3'd1,
      FS_B_MISSING = 3'd2,
      FS_C_MISSING = 3'd3,
      FS_C_HELD    = 3'd4,
      FS_TIMEOUT   = 3'd5
   } fail_stage_e;

endpackage

// File: rtl/seq_mon_sat_cnt.sv
// Saturating event counter: counts one per cycle while inc_i is high,
// sticks at all-ones, and clears only on reset.
module seq_mon_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;

   // Count up on each event, holding once every bit is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/seq_expect_monitor.sv
// Single-attempt hardware checker for the handshake a ##1 b ##1 c ##1 !c.
// Each start pulse accepted in IDLE arms one attempt; the outcome is a
// one-cycle pass or fail pulse plus a sticky fail_stage code.
// Optional feature macro: SEQ_MON_COUNT_EN builds saturating pass/fail
// counters; without it pass_cnt/fail_cnt are constant zero.
module seq_expect_monitor
   import seq_mon_pkg::*;
#(
   parameter int WAIT_FOR_A     = 0,
   parameter int TIMEOUT_CYCLES = 20000,
   parameter int CNT_W          = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    a,
   input  logic                    b,
   input  logic                    c,
   output logic                    busy,
   output logic                    pass,
   output logic                    fail,
   output logic [FAIL_STAGE_W-1:0] fail_stage,
   output logic [CNT_W-1:0]        pass_cnt,
   output logic [CNT_W-1:0]        fail_cnt
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   seq_state_e        state_q, state_d;
   fail_stage_e       stage_q, stage_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              busy_q, busy_d;
   logic              pass_q, pass_d;
   logic              fail_q, fail_d;

   // State, timeout counter and all visible outputs are registered so the
   // result pulses and busy change together on the deciding edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         stage_q <= FS_NONE;
         tmo_q   <= '0;
         busy_q  <= 1'b0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         tmo_q   <= tmo_d;
         busy_q  <= busy_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   // Next-state decisions: each EXP_* state checks only its own strobe,
   // and any miss ends the attempt with the matching code. An unknown
   // strobe falls into the else branches, so it counts as low.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      tmo_d   = tmo_q;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = EXP_A;
               stage_d = FS_NONE;
               tmo_d   = '0;
            end
         end
         EXP_A: begin
            if (a) begin
               state_d = EXP_B;
            end else if (WAIT_FOR_A == 0) begin
               state_d = IDLE;
               stage_d = FS_A_MISSING;
               fail_d  = 1'b1;
            end else if (tmo_q == TMO_LAST) begin
               state_d = IDLE;
               stage_d = FS_TIMEOUT;
               fail_d  = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         EXP_B: begin
            if (b) begin
               state_d = EXP_C;
            end else begin
               state_d = IDLE;
               stage_d = FS_B_MISSING;
               fail_d  = 1'b1;
            end
         end
         EXP_C: begin
            if (c) begin
               state_d = EXP_NC;
            end else begin
               state_d = IDLE;
               stage_d = FS_C_MISSING;
               fail_d  = 1'b1;
            end
         end
         EXP_NC: begin
            state_d = IDLE;
            if (c) begin
               stage_d = FS_C_HELD;
               fail_d  = 1'b1;
            end else begin
               pass_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   assign busy       = busy_q;
   assign pass       = pass_q;
   assign fail       = fail_q;
   assign fail_stage = stage_q;

`ifdef SEQ_MON_COUNT_EN
   seq_mon_sat_cnt #(.W(CNT_W)) u_pass_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (pass_d),
      .count_o (pass_cnt)
   );

   seq_mon_sat_cnt #(.W(CNT_W)) u_fail_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc_i   (fail_d),
      .count_o (fail_cnt)
   );
`else
   assign pass_cnt = '0;
   assign fail_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_expect_monitor.sv
// Bench for seq_expect_monitor: a strict instance and a wait-for-a instance
// (timeout 5) share one stimulus stream made of a directed prefix followed
// by random traffic, and a reference model predicts each attempt's outcome.
module tb_seq_expect_monitor;

   localparam int L    = 400;
   localparam int TMO  = 5;
   localparam int CW   = 2;
   localparam int CMAX = 3;

`ifdef SEQ_MON_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic start, a, b, c;

   logic [1:0]         busyO, passO, failO;
   logic [1:0][2:0]    stageO;
   logic [1:0][CW-1:0] pcO, fcO;

   int vectors = 0;
   int miscompares = 0;

   bit sArr[L];
   bit aArr[L];
   bit bArr[L];
   bit cArr[L];

   int expBusy[2][L];
   int expPass[2][L];
   int expFail[2][L];
   int expStage[2][L];
   int expPc[2][L];
   int expFc[2][L];

   seq_expect_monitor #(.WAIT_FOR_A(0), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) u_strict (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
      .busy(busyO[0]), .pass(passO[0]), .fail(failO[0]),
      .fail_stage(stageO[0]), .pass_cnt(pcO[0]), .fail_cnt(fcO[0])
   );

   seq_expect_monitor #(.WAIT_FOR_A(1), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) u_wait (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c(c),
      .busy(busyO[1]), .pass(passO[1]), .fail(failO[1]),
      .fail_stage(stageO[1]), .pass_cnt(pcO[1]), .fail_cnt(fcO[1])
   );

   // Free-running sampling clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      if (obs !== expv) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic applyStimulus(input bit s, input bit av, input bit bv, input bit cv);
      @(negedge clk);
      start = s;
      a     = av;
      b     = bv;
      c     = cv;
   endtask

   task automatic setV(input int k, input bit s, input bit av, input bit bv, input bit cv);
      sArr[k] = s;
      aArr[k] = av;
      bArr[k] = bv;
      cArr[k] = cv;
   endtask

   function automatic int satInc(input int v);
      if (!CNT_EN) return 0;
      return (v < CMAX) ? v + 1 : CMAX;
   endfunction

   task automatic setExp(input int m, input int k, input int bz, input int p, input int f,
                         input int st, input int pc, input int fc);
      expBusy[m][k]  = bz;
      expPass[m][k]  = p;
      expFail[m][k]  = f;
      expStage[m][k] = st;
      expPc[m][k]    = pc;
      expFc[m][k]    = fc;
   endtask

   // Attempt-level model: an accepted start at edge k looks for a within
   // the allowed window, then b, c and released c on the following edges.
   task automatic buildExpect(input int m, input bit waitMode);
      int k, e, code, stage, pc, fc, limit;
      bit found;
      k = 0; stage = 0; pc = 0; fc = 0;
      while (k < L) begin
         if (sArr[k]) begin
            limit = waitMode ? TMO : 1;
            found = 1'b0;
            e     = k + limit;
            code  = waitMode ? 5 : 1;
            for (int j = 1; j <= limit; j++) begin
               if (!found && aArr[k + j]) begin
                  found = 1'b1;
                  e     = k + j;
               end
            end
            if (found) begin
               if (!bArr[e + 1]) begin
                  e = e + 1; code = 2;
               end else if (!cArr[e + 2]) begin
                  e = e + 2; code = 3;
               end else begin
                  e = e + 3; code = cArr[e] ? 4 : 0;
               end
            end
            for (int j = k; j < e; j++) setExp(m, j, 1, 0, 0, 0, pc, fc);
            if (code == 0) pc = satInc(pc);
            else           fc = satInc(fc);
            stage = code;
            setExp(m, e, 0, (code == 0) ? 1 : 0, (code != 0) ? 1 : 0, stage, pc, fc);
            k = e + 1;
         end else begin
            setExp(m, k, 0, 0, 0, stage, pc, fc);
            k++;
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; a = 1'b0; b = 1'b0; c = 1'b0;

      for (int k = 0; k < L; k++) setV(k, 0, 0, 0, 0);
      // strict pass
      setV(0, 1, 0, 0, 0); setV(1, 0, 1, 0, 0); setV(2, 0, 0, 1, 0);
      setV(3, 0, 0, 0, 1); setV(4, 0, 0, 0, 0);
      // c held high
      setV(6, 1, 0, 0, 0); setV(7, 0, 1, 0, 0); setV(8, 0, 0, 1, 0);
      setV(9, 0, 0, 0, 1); setV(10, 0, 0, 0, 1);
      // b missing, start during EXP_B ignored
      setV(12, 1, 0, 0, 0); setV(13, 0, 1, 0, 0); setV(14, 1, 0, 0, 0);
      // a never high: strict fails stage 1, waiting instance times out
      setV(16, 1, 0, 0, 0);
      // late a at N+3
      setV(23, 1, 0, 0, 0); setV(26, 0, 1, 0, 0); setV(27, 0, 0, 1, 0);
      setV(28, 0, 0, 0, 1); setV(29, 0, 0, 0, 0);
      for (int k = 31; k < L - 12; k++) begin
         setV(k, ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) != 0),
              ($urandom_range(0, 6) != 0), ($urandom_range(0, 1) == 1));
      end
      for (int k = L - 12; k < L; k++) setV(k, 0, $urandom_range(0, 1) == 1, 0, 0);

      buildExpect(0, 1'b0);
      buildExpect(1, 1'b1);

      repeat (2) @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         checkOutput($sformatf("reset busy m%0d", m), 32'(busyO[m]), 0);
         checkOutput($sformatf("reset pass m%0d", m), 32'(passO[m]), 0);
         checkOutput($sformatf("reset fail m%0d", m), 32'(failO[m]), 0);
         checkOutput($sformatf("reset stage m%0d", m), 32'(stageO[m]), 0);
         checkOutput($sformatf("reset pcnt m%0d", m), 32'(pcO[m]), 0);
         checkOutput($sformatf("reset fcnt m%0d", m), 32'(fcO[m]), 0);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < L; k++) begin
         applyStimulus(sArr[k], aArr[k], bArr[k], cArr[k]);
         @(posedge clk);
         #1;
         for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("busy m%0d e%0d", m, k), 32'(busyO[m]), expBusy[m][k]);
            checkOutput($sformatf("pass m%0d e%0d", m, k), 32'(passO[m]), expPass[m][k]);
            checkOutput($sformatf("fail m%0d e%0d", m, k), 32'(failO[m]), expFail[m][k]);
            checkOutput($sformatf("stage m%0d e%0d", m, k), 32'(stageO[m]), expStage[m][k]);
            checkOutput($sformatf("pcnt m%0d e%0d", m, k), 32'(pcO[m]), expPc[m][k]);
            checkOutput($sformatf("fcnt m%0d e%0d", m, k), 32'(fcO[m]), expFc[m][k]);
         end
      end

      // Reset while both instances sit in EXP_C.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0);
      @(posedge clk);
      #1;
      checkOutput("pre-reset busy strict", 32'(busyO[0]), 1);
      checkOutput("pre-reset busy wait", 32'(busyO[1]), 1);
      #2;
      rst = 1'b1;
      #1;
      for (int m = 0; m < 2; m++) begin
         checkOutput($sformatf("async rst busy m%0d", m), 32'(busyO[m]), 0);
         checkOutput($sformatf("async rst pass m%0d", m), 32'(passO[m]), 0);
         checkOutput($sformatf("async rst fail m%0d", m), 32'(failO[m]), 0);
         checkOutput($sformatf("async rst pcnt m%0d", m), 32'(pcO[m]), 0);
      end
      start = 1'b0; a = 1'b0; b = 1'b0; c = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("held rst fail strict", 32'(failO[0]), 0);
      checkOutput("held rst pass strict", 32'(passO[0]), 0);
      @(negedge clk);
      rst = 1'b0;

      // Fresh attempt after the abort runs to a normal pass.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0);
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         checkOutput($sformatf("post-rst pass m%0d", m), 32'(passO[m]), 1);
         checkOutput($sformatf("post-rst fail m%0d", m), 32'(failO[m]), 0);
         checkOutput($sformatf("post-rst busy m%0d", m), 32'(busyO[m]), 0);
         checkOutput($sformatf("post-rst stage m%0d", m), 32'(stageO[m]), 0);
         checkOutput($sformatf("post-rst pcnt m%0d", m), 32'(pcO[m]), CNT_EN ? 1 : 0);
      end
      @(posedge clk);
      #1;
      checkOutput("pass width strict", 32'(passO[0]), 0);
      checkOutput("pass width wait", 32'(passO[1]), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seq_expect_monitor.md
Name: seq_expect_monitor

Overview:
- Synthesizable, single-attempt checker for the 4-cycle handshake `a ##1 b ##1 c ##1 !c` on three 1-bit strobes.
- Sits directly downstream of the a/b/c stimulus driver.
- Gives a hardware pass/fail result equivalent to a simulation `expect` with a timeout, so the same check runs in emulation/FPGA and is visible to firmware.
- One attempt per `start` pulse; result reported as one-cycle pulses plus a sticky status code.

Parameters:
- WAIT_FOR_A, 0: 0 = `a` must be high on the first sample after arming (strict expect semantics); 1 = wait for first `a`, bounded by the timeout.
- TIMEOUT_CYCLES, 20000: maximum WAIT_A dwell cycles when WAIT_FOR_A=1; must be ≥1.
- CNT_W, 16: width of the optional pass/fail counters.

Ports:
- clk  in  1  sampling clock; all inputs sampled on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  arm one attempt; honoured only in IDLE.
- a  in  1  first strobe.
- b  in  1  second strobe.
- c  in  1  third strobe.
- busy  out  1  high while an attempt is in progress.
- pass  out  1  one-cycle pulse: sequence matched.
- fail  out  1  one-cycle pulse: sequence violated or timed out.
- fail_stage  out  3  sticky code of last result: 0 none/pass, 1 a missing, 2 b missing, 3 c missing, 4 c not released, 5 timeout.
- pass_cnt  out  CNT_W  saturating pass count (SEQ_MON_COUNT_EN only).
- fail_cnt  out  CNT_W  saturating fail count (SEQ_MON_COUNT_EN only).

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE; busy, pass, fail = 0; fail_stage=0; counters=0; timeout counter=0.
- A reset asserted mid-attempt aborts it immediately; no pass/fail pulse is produced.
- States: IDLE, EXP_A, EXP_B, EXP_C, EXP_NC.
- IDLE: start=1 at edge N → EXP_A and busy=1 from edge N; clear fail_stage to 0 and the timeout counter.
- EXP_A at edge N+1:
  - a=1 → EXP_B.
  - a=0 and WAIT_FOR_A=0 → fail, stage 1, IDLE.
  - a=0 and WAIT_FOR_A=1 → stay and increment the timeout counter.
  - When the counter reaches TIMEOUT_CYCLES → fail, stage 5, IDLE.
- EXP_B: b=1 → EXP_C, else fail stage 2.
- EXP_C: c=1 → EXP_NC, else fail stage 3.
- EXP_NC: c=0 → pass; c=1 → fail stage 4. Either way → IDLE.
- Latency: strict-mode match gives pass=1 registered at edge N+4, exactly one cycle; busy drops at the same edge.
- Outputs are registered; pass and fail are never high together.
- Only listed signals are checked: a, b, c values outside their checked cycle are ignored (e.g. a=1 during EXP_B is legal).
- start while busy is ignored; there is no queueing.
- start in the same cycle the result pulses: state is already IDLE at that edge, so the start is sampled on the next edge only if still held.
- X on a checked input is treated as 0 for state decisions.
- Timeout counter width: $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro SEQ_MON_COUNT_EN.
- Defined: pass_cnt/fail_cnt increment on each pass/fail pulse, saturate at all-ones, clear only on rst.
- Undefined: both ports still exist and are tied to 0; no counter flops are built.

Decomposition:
- Package seq_mon_pkg holds:
  - state enum seq_state_e (IDLE, EXP_A, EXP_B, EXP_C, EXP_NC);
  - fail code enum fail_stage_e (3-bit, values above);
  - localparam FAIL_STAGE_W=3.
- Sub-module seq_mon_sat_cnt: generic saturating counter, instantiated twice under SEQ_MON_COUNT_EN.

Test Plan:
- Strict, in-spec: start@N, a=1@N+1, b=1@N+2, c=1@N+3, c=0@N+4 → pass pulse at N+4 for 1 cycle, fail_stage=0, busy low at N+4, pass_cnt=1.
- c held high: same stimulus but c=1@N+4 → fail pulse at N+4, fail_stage=4, fail_cnt=1.
- Missing b: a=1@N+1, b=0@N+2 → fail at N+2, fail_stage=2; start during EXP_B ignored, busy stays high until fail.
- WAIT_FOR_A=1, TIMEOUT_CYCLES=5, a never high → fail at N+5, fail_stage=5.
  - Repeat with a=1@N+3, then the b/c/!c pattern → pass at N+6.
- Reset mid-operation: rst asserted during EXP_C → busy/pass/fail=0 asynchronously, no pulse; the next start runs normally to pass.
- Counter saturation (CNT_W=2, macro defined): 5 consecutive passing attempts → pass_cnt=3 and holds.
  - Macro undefined: pass_cnt stays 0.
